// File: rtl/sync_fifo_if.sv
// Request/status bundle for sync_fifo: the master issues writes, reads and control pulses,
// and the slave (the FIFO) returns read data and status flags.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_data, wr_en, rd_en, flush, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en, flush, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level-based full/empty, programmable almost flags, sticky error
// flags, synchronous flush, and a choice of registered or first-word fall-through reads.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);
  localparam int              DEPTH   = 2 ** ADDR_WIDTH;
  localparam int              LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]   AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0]   AE_L    = LW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, empty_q, af_q, ae_q;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_s, rd_acc_s;

  // Acceptance, pointer/level next state and sticky error update
  always_comb begin
    wr_acc_s    = bus.wr_en & ~full_q  & ~bus.flush;
    rd_acc_s    = bus.rd_en & ~empty_q & ~bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = {ADDR_WIDTH{1'b0}};
      rd_ptr_d = {ADDR_WIDTH{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    // A new error in the same cycle as clr_err keeps the flag set
    overflow_d  = (bus.wr_en & full_q  & ~bus.flush) | (overflow_q  & ~bus.clr_err);
    underflow_d = (bus.rd_en & empty_q & ~bus.flush) | (underflow_q & ~bus.clr_err);
  end

  // Control state, read port and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      level_q     <= {LW{1'b0}};
      rd_data_q   <= {DATA_WIDTH{1'b0}};
      rd_valid_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      full_q      <= (level_d == DEPTH_L);
      empty_q     <= (level_d == {LW{1'b0}});
      af_q        <= (level_d >= AF_L);
      ae_q        <= (level_d <= AE_L);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset and flush
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Fall-through mode shows the head word combinationally while not empty
  assign bus.rd_data      = (FWFT != 0) ? (empty_q ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q]) : rd_data_q;
  assign bus.rd_valid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read instance and a fall-through instance.
module tb_sync_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sync_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) a ();
  sync_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b ();

  sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a.wr_data = 16'h0000; a.wr_en = 1'b0; a.rd_en = 1'b0; a.flush = 1'b0; a.clr_err = 1'b0;
    b.wr_data = 16'h0000; b.wr_en = 1'b0; b.rd_en = 1'b0; b.flush = 1'b0; b.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (a.level !== 5'd0 || a.empty !== 1'b1 || a.full !== 1'b0 || a.almost_empty !== 1'b1 ||
        a.almost_full !== 1'b0 || a.rd_valid !== 1'b0 || a.rd_data !== 16'h0000 ||
        a.overflow !== 1'b0 || a.underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state lvl=%0d e=%b f=%b ae=%b af=%b v=%b d=%h ov=%b un=%b exp lvl=0 e=1 f=0 ae=1 af=0 v=0 d=0 ov=0 un=0",
               a.level, a.empty, a.full, a.almost_empty, a.almost_full, a.rd_valid, a.rd_data, a.overflow, a.underflow);
    end
  endtask

  task automatic test_fill_and_drain();
    for (int i = 0; i < 16; i++) begin
      a.wr_data = 16'(i); a.wr_en = 1'b1;
      tick();
      checks++;
      if (a.level !== 5'(i + 1) || a.almost_full !== (i + 1 >= 14) || a.almost_empty !== (i + 1 <= 2)) begin
        failures++;
        $display("FAIL fill_level step=%0d lvl=%0d af=%b ae=%b exp lvl=%0d af=%b ae=%b",
                 i, a.level, a.almost_full, a.almost_empty, i + 1, (i + 1 >= 14), (i + 1 <= 2));
      end
    end
    checks++;
    if (a.full !== 1'b1 || a.empty !== 1'b0 || a.overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_flag f=%b e=%b ov=%b exp f=1 e=0 ov=0", a.full, a.empty, a.overflow);
    end
    a.wr_data = 16'hDEAD;
    tick();
    a.wr_en = 1'b0;
    checks++;
    if (a.overflow !== 1'b1 || a.level !== 5'd16) begin
      failures++;
      $display("FAIL overflow_drop ov=%b lvl=%0d exp ov=1 lvl=16", a.overflow, a.level);
    end
    a.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (a.rd_data !== 16'(i) || a.rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_data idx=%0d got=%h v=%b exp=%h v=1", i, a.rd_data, a.rd_valid, 16'(i));
      end
    end
    a.rd_en = 1'b0;
    checks++;
    if (a.empty !== 1'b1 || a.level !== 5'd0) begin
      failures++;
      $display("FAIL drain_empty e=%b lvl=%0d exp e=1 lvl=0", a.empty, a.level);
    end
    tick();
    checks++;
    if (a.rd_valid !== 1'b0 || a.rd_data !== 16'd15) begin
      failures++;
      $display("FAIL valid_single v=%b d=%h exp v=0 d=000f", a.rd_valid, a.rd_data);
    end
    a.clr_err = 1'b1;
    tick();
    a.clr_err = 1'b0;
    checks++;
    if (a.overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear ov=%b exp=0", a.overflow);
    end
  endtask

  task automatic test_underflow();
    a.rd_en = 1'b1;
    tick();
    a.rd_en = 1'b0;
    checks++;
    if (a.underflow !== 1'b1 || a.level !== 5'd0 || a.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL underflow_set un=%b lvl=%0d v=%b exp un=1 lvl=0 v=0", a.underflow, a.level, a.rd_valid);
    end
    a.clr_err = 1'b1;
    tick();
    checks++;
    if (a.underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear un=%b exp=0", a.underflow);
    end
    a.rd_en = 1'b1;
    tick();
    a.rd_en = 1'b0; a.clr_err = 1'b0;
    checks++;
    if (a.underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set_wins un=%b exp=1", a.underflow);
    end
    a.clr_err = 1'b1;
    tick();
    a.clr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      a.wr_data = 16'hF000 + 16'(i); a.wr_en = 1'b1;
      tick();
    end
    a.rd_en = 1'b1;
    for (int j = 0; j < 50; j++) begin
      a.wr_data = 16'(j);
      tick();
      exp_d = (j < 8) ? (16'hF000 + 16'(j)) : 16'(j - 8);
      checks++;
      if (a.rd_data !== exp_d || a.level !== 5'd8 || a.rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_stream cyc=%0d got=%h lvl=%0d v=%b exp=%h lvl=8 v=1", j, a.rd_data, a.level, a.rd_valid, exp_d);
      end
    end
    a.wr_en = 1'b0;
    for (int j = 42; j < 50; j++) begin
      tick();
      checks++;
      if (a.rd_data !== 16'(j)) begin
        failures++;
        $display("FAIL b2b_drain got=%h exp=%h", a.rd_data, 16'(j));
      end
    end
    a.rd_en = 1'b0;
    tick();
    checks++;
    if (a.empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_empty e=%b exp=1", a.empty);
    end
  endtask

  task automatic test_flush();
    a.rd_en = 1'b1;
    tick();
    a.rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a.wr_data = 16'h0020 + 16'(i); a.wr_en = 1'b1;
      tick();
    end
    a.flush = 1'b1; a.rd_en = 1'b1; a.wr_data = 16'h7777;
    tick();
    a.flush = 1'b0; a.rd_en = 1'b0; a.wr_en = 1'b0;
    checks++;
    if (a.level !== 5'd0 || a.empty !== 1'b1 || a.almost_empty !== 1'b1 || a.rd_valid !== 1'b0 ||
        a.rd_data !== 16'd49 || a.underflow !== 1'b1 || a.overflow !== 1'b0) begin
      failures++;
      $display("FAIL flush_state lvl=%0d e=%b ae=%b v=%b d=%h un=%b ov=%b exp lvl=0 e=1 ae=1 v=0 d=0031 un=1 ov=0",
               a.level, a.empty, a.almost_empty, a.rd_valid, a.rd_data, a.underflow, a.overflow);
    end
    a.wr_data = 16'h0055; a.wr_en = 1'b1;
    tick();
    a.wr_en = 1'b0; a.rd_en = 1'b1;
    tick();
    a.rd_en = 1'b0;
    checks++;
    if (a.rd_data !== 16'h0055 || a.rd_valid !== 1'b1 || a.level !== 5'd0) begin
      failures++;
      $display("FAIL flush_reuse got=%h v=%b lvl=%0d exp=0055 v=1 lvl=0", a.rd_data, a.rd_valid, a.level);
    end
    a.clr_err = 1'b1;
    tick();
    a.clr_err = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      a.wr_data = 16'h0040 + 16'(i); a.wr_en = 1'b1;
      tick();
    end
    a.wr_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a.level !== 5'd0 || a.empty !== 1'b1 || a.full !== 1'b0 || a.almost_empty !== 1'b1 ||
        a.almost_full !== 1'b0 || a.rd_valid !== 1'b0 || a.rd_data !== 16'h0000 ||
        a.overflow !== 1'b0 || a.underflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset lvl=%0d e=%b ae=%b v=%b d=%h exp lvl=0 e=1 ae=1 v=0 d=0000",
               a.level, a.empty, a.almost_empty, a.rd_valid, a.rd_data);
    end
    #2;
    rst_n = 1'b1;
    tick();
    a.wr_data = 16'h0007; a.wr_en = 1'b1;
    tick();
    a.wr_en = 1'b0; a.rd_en = 1'b1;
    tick();
    a.rd_en = 1'b0;
    checks++;
    if (a.rd_data !== 16'h0007 || a.rd_valid !== 1'b1 || a.empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_read got=%h v=%b e=%b exp=0007 v=1 e=1", a.rd_data, a.rd_valid, a.empty);
    end
  endtask

  task automatic test_fwft();
    b.wr_data = 16'hA5A5; b.wr_en = 1'b1;
    tick();
    b.wr_en = 1'b0;
    checks++;
    if (b.rd_data !== 16'hA5A5 || b.rd_valid !== 1'b1 || b.empty !== 1'b0) begin
      failures++;
      $display("FAIL fwft_present got=%h v=%b e=%b exp=a5a5 v=1 e=0", b.rd_data, b.rd_valid, b.empty);
    end
    tick();
    checks++;
    if (b.rd_data !== 16'hA5A5 || b.rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL fwft_hold got=%h v=%b exp=a5a5 v=1", b.rd_data, b.rd_valid);
    end
    b.rd_en = 1'b1;
    tick();
    b.rd_en = 1'b0;
    checks++;
    if (b.empty !== 1'b1 || b.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL fwft_ack e=%b v=%b exp e=1 v=0", b.empty, b.rd_valid);
    end
    b.wr_en = 1'b1;
    b.wr_data = 16'h0001;
    tick();
    b.wr_data = 16'h0002;
    tick();
    b.wr_en = 1'b0;
    checks++;
    if (b.rd_data !== 16'h0001 || b.level !== 5'd2) begin
      failures++;
      $display("FAIL fwft_order_head got=%h lvl=%0d exp=0001 lvl=2", b.rd_data, b.level);
    end
    b.rd_en = 1'b1;
    tick();
    checks++;
    if (b.rd_data !== 16'h0002 || b.rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL fwft_order_next got=%h v=%b exp=0002 v=1", b.rd_data, b.rd_valid);
    end
    tick();
    b.rd_en = 1'b0;
    checks++;
    if (b.empty !== 1'b1 || b.underflow !== 1'b0) begin
      failures++;
      $display("FAIL fwft_drain e=%b un=%b exp e=1 un=0", b.empty, b.underflow);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b0;
    #23;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_fill_and_drain();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
